// File: rtl/biriscv_icache_resp_pkg.sv
// Shared definitions for the instruction cache responder: FSM encoding,
// address-split width helpers and privilege constants.
package biriscv_icache_resp_pkg;

  localparam logic [1:0] PRIV_MACHINE = 2'd3;

  localparam logic [2:0] STATE_FLUSH  = 3'd0;
  localparam logic [2:0] STATE_LOOKUP = 3'd1;
  localparam logic [2:0] STATE_REFILL = 3'd2;
  localparam logic [2:0] STATE_WAIT   = 3'd3;
  localparam logic [2:0] STATE_RESP   = 3'd4;

  typedef enum logic [2:0] {
    ST_FLUSH  = STATE_FLUSH,
    ST_LOOKUP = STATE_LOOKUP,
    ST_REFILL = STATE_REFILL,
    ST_WAIT   = STATE_WAIT,
    ST_RESP   = STATE_RESP
  } state_t;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Byte offset within a 64-bit word is always 3 bits.
  function automatic int tag_bits(input int num_lines, input int line_words);
    return 32 - 3 - word_bits(line_words) - index_bits(num_lines);
  endfunction

endpackage

// File: rtl/biriscv_icache_resp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module biriscv_icache_resp_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/biriscv_icache_resp.sv
// Direct-mapped read-only instruction cache answering the fetch unit's icache_* port.
// Optional: define BIRISCV_ICACHE_UNCACHED_EN to bypass the cache when pc[31:28]==UNCACHED_TOP.
module biriscv_icache_resp
  import biriscv_icache_resp_pkg::*;
#(
  parameter int         NUM_LINES    = 64,
  parameter int         LINE_WORDS   = 4,
  parameter logic [3:0] UNCACHED_TOP = 4'hF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        icache_rd_i,
  input  logic [31:0] icache_pc_i,
  input  logic [1:0]  icache_priv_i,
  input  logic        icache_flush_i,
  input  logic        icache_invalidate_i,
  output logic        icache_accept_o,
  output logic        icache_valid_o,
  output logic [63:0] icache_inst_o,
  output logic        icache_error_o,
  output logic        icache_page_fault_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_len_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [63:0] mem_data_i,
  input  logic        mem_error_i,
  input  logic        mem_last_i
);

  localparam int WORD_W = word_bits(LINE_WORDS);
  localparam int IDX_W  = index_bits(NUM_LINES);
  localparam int TAG_W  = tag_bits(NUM_LINES, LINE_WORDS);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    flush_cnt_q;
  logic                flush_pend_q;
  logic                req_pending_q;
  logic                req_uncached_q;
  logic [28:0]         req_pc_q;
  logic [WORD_W-1:0]   beat_cnt_q;
  logic                err_q;
  logic [63:0]         resp_data_q;

  logic [WORD_W-1:0]   req_word;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;

  logic                flush_in, flush_any, compare, hit, miss;
  logic                beat, err_next, line_full, req_fire, pc_uncached;

  logic                tag_we;
  logic [IDX_W-1:0]    tag_waddr;
  logic [TAG_W:0]      tag_wdata, tag_rdata;
  logic                data_we;
  logic [IDX_W+WORD_W-1:0] data_waddr;
  logic [63:0]         data_rdata;

  logic                unused_sig;

  assign req_word = req_pc_q[WORD_W-1:0];
  assign req_idx  = req_pc_q[WORD_W +: IDX_W];
  assign req_tag  = req_pc_q[WORD_W+IDX_W +: TAG_W];

`ifdef BIRISCV_ICACHE_UNCACHED_EN
  assign pc_uncached = (icache_pc_i[31:28] == UNCACHED_TOP);
`else
  assign pc_uncached = 1'b0;
`endif

  // A flush that cannot be taken immediately is remembered in flush_pend_q.
  assign flush_in  = icache_flush_i | icache_invalidate_i;
  assign flush_any = flush_in | flush_pend_q;
  assign compare   = (state_q == ST_LOOKUP) & req_pending_q;
  assign hit       = compare & tag_rdata[TAG_W] & (tag_rdata[TAG_W-1:0] == req_tag) & ~req_uncached_q;
  assign miss      = compare & ~hit;
  assign beat      = (state_q == ST_WAIT) & mem_valid_i;
  assign err_next  = err_q | (beat & mem_error_i);
  assign line_full = (beat_cnt_q == WORD_W'(LINE_WORDS - 1));
  assign req_fire  = icache_accept_o & icache_rd_i;

  assign icache_page_fault_o = 1'b0;
  assign unused_sig = ^{icache_priv_i, icache_pc_i[2:0], UNCACHED_TOP};

  biriscv_icache_resp_ram #(.AW(IDX_W), .DW(TAG_W + 1)) u_tag_ram (
    .clk_i   (clk_i),
    .wr_en   (tag_we),
    .wr_addr (tag_waddr),
    .wr_data (tag_wdata),
    .rd_addr (icache_pc_i[3+WORD_W +: IDX_W]),
    .rd_data (tag_rdata)
  );

  biriscv_icache_resp_ram #(.AW(IDX_W + WORD_W), .DW(64)) u_data_ram (
    .clk_i   (clk_i),
    .wr_en   (data_we),
    .wr_addr (data_waddr),
    .wr_data (mem_data_i),
    .rd_addr (icache_pc_i[3 +: IDX_W+WORD_W]),
    .rd_data (data_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_FLUSH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH:  if (!flush_in && flush_cnt_q == IDX_W'(NUM_LINES - 1)) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (miss)           state_d = ST_REFILL;
        else if (flush_any) state_d = ST_FLUSH;
      end
      ST_REFILL: if (mem_accept_i) state_d = ST_WAIT;
      ST_WAIT:   if (beat && mem_last_i) state_d = ST_RESP;
      ST_RESP:   state_d = flush_any ? ST_FLUSH : ST_LOOKUP;
      default:   state_d = ST_FLUSH;
    endcase
  end

  // Outputs and RAM write ports; the tag RAM port is shared by flush clearing and line fill.
  always_comb begin
    icache_accept_o = 1'b0;
    icache_valid_o  = 1'b0;
    icache_inst_o   = 64'd0;
    icache_error_o  = 1'b0;
    mem_rd_o        = 1'b0;
    mem_addr_o      = 32'd0;
    mem_len_o       = 8'd0;
    tag_we          = 1'b0;
    tag_waddr       = req_idx;
    tag_wdata       = {~err_next & line_full & ~flush_any, req_tag};
    data_we         = 1'b0;
    data_waddr      = {req_idx, beat_cnt_q};
    case (state_q)
      ST_FLUSH: begin
        tag_we    = 1'b1;
        tag_waddr = flush_cnt_q;
        tag_wdata = '0;
      end
      ST_LOOKUP: begin
        icache_accept_o = ~flush_any & (~compare | hit);
        icache_valid_o  = hit;
        icache_inst_o   = hit ? data_rdata : 64'd0;
      end
      ST_REFILL: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = req_uncached_q ? {req_pc_q, 3'b000}
                                    : {req_pc_q[28:WORD_W], {WORD_W{1'b0}}, 3'b000};
        mem_len_o  = req_uncached_q ? 8'd0 : 8'(LINE_WORDS - 1);
      end
      ST_WAIT: begin
        data_we = beat & ~req_uncached_q;
        tag_we  = beat & mem_last_i & ~req_uncached_q;
      end
      ST_RESP: begin
        icache_valid_o = 1'b1;
        icache_inst_o  = resp_data_q;
        icache_error_o = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_q    <= '0;
      flush_pend_q   <= 1'b0;
      req_pending_q  <= 1'b0;
      req_uncached_q <= 1'b0;
      req_pc_q       <= '0;
      beat_cnt_q     <= '0;
      err_q          <= 1'b0;
      resp_data_q    <= 64'd0;
    end else begin
      req_pending_q <= req_fire;
      if (req_fire) begin
        req_pc_q       <= icache_pc_i[31:3];
        req_uncached_q <= pc_uncached;
      end
      if (state_q == ST_FLUSH || state_d == ST_FLUSH) flush_pend_q <= 1'b0;
      else                                            flush_pend_q <= flush_pend_q | flush_in;
      if (state_d == ST_FLUSH)
        flush_cnt_q <= (state_q == ST_FLUSH && !flush_in) ? flush_cnt_q + IDX_W'(1) : '0;
      if (state_q == ST_REFILL) beat_cnt_q <= '0;
      else if (beat)            beat_cnt_q <= beat_cnt_q + WORD_W'(1);
      if (beat && (req_uncached_q || beat_cnt_q == req_word)) resp_data_q <= mem_data_i;
      err_q <= (state_q == ST_RESP) ? 1'b0 : err_next;
    end
  end

endmodule

// File: tb/tb_biriscv_icache_resp.sv
// Directed bench for biriscv_icache_resp: bench acts as fetch unit and burst memory,
// expected responses are queued on acceptance and checked when icache_valid_o fires.
module tb_biriscv_icache_resp;
  import biriscv_icache_resp_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        icache_rd_i;
  logic [31:0] icache_pc_i;
  logic [1:0]  icache_priv_i;
  logic        icache_flush_i;
  logic        icache_invalidate_i;
  logic        icache_accept_o;
  logic        icache_valid_o;
  logic [63:0] icache_inst_o;
  logic        icache_error_o;
  logic        icache_page_fault_o;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_len_o;
  logic        mem_accept_i;
  logic        mem_valid_i;
  logic [63:0] mem_data_i;
  logic        mem_error_i;
  logic        mem_last_i;

  typedef struct packed {
    logic [63:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   valid_cycles[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   mem_rd_cycles = 0;

  always #5 clk_i = ~clk_i;

  biriscv_icache_resp #(.NUM_LINES(64), .LINE_WORDS(4), .UNCACHED_TOP(4'hF)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .icache_rd_i         (icache_rd_i),
    .icache_pc_i         (icache_pc_i),
    .icache_priv_i       (icache_priv_i),
    .icache_flush_i      (icache_flush_i),
    .icache_invalidate_i (icache_invalidate_i),
    .icache_accept_o     (icache_accept_o),
    .icache_valid_o      (icache_valid_o),
    .icache_inst_o       (icache_inst_o),
    .icache_error_o      (icache_error_o),
    .icache_page_fault_o (icache_page_fault_o),
    .mem_rd_o            (mem_rd_o),
    .mem_addr_o          (mem_addr_o),
    .mem_len_o           (mem_len_o),
    .mem_accept_i        (mem_accept_i),
    .mem_valid_i         (mem_valid_i),
    .mem_data_i          (mem_data_i),
    .mem_error_i         (mem_error_i),
    .mem_last_i          (mem_last_i)
  );

  function automatic logic [63:0] memWord(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cycle <= cycle + 1;

  // Response monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (mem_rd_o) mem_rd_cycles++;
      if (icache_valid_o) begin
        valid_cycles.push_back(cycle);
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 64'(icache_valid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_inst", icache_inst_o, e.inst);
          checkOutput("resp_error", 64'(icache_error_o), 64'(e.err));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [63:0] exp_inst,
                               input logic exp_err, output int waited);
    bit done = 0;
    icache_rd_i = 1'b1;
    icache_pc_i = pc;
    waited = 0;
    while (!done) begin
      @(negedge clk_i);
      if (icache_accept_o) begin
        sb.push_back('{inst: exp_inst, err: exp_err});
        done = 1;
      end else if (waited >= 200) begin
        checkOutput("accept_timeout", 64'(icache_accept_o), 64'd1);
        done = 1;
      end else begin
        waited++;
      end
      @(posedge clk_i); #1;
    end
    icache_rd_i = 1'b0;
  endtask

  task automatic serveBurst(input logic [31:0] exp_addr, input logic [7:0] exp_len,
                            input int nbeats, input int err_beat, input int flush_beat);
    int n = 0;
    while (!mem_rd_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!mem_rd_o) begin
      checkOutput("mem_rd_timeout", 64'(mem_rd_o), 64'd1);
      @(posedge clk_i); #1;
      return;
    end
    checkOutput("mem_addr", 64'(mem_addr_o), 64'(exp_addr));
    checkOutput("mem_len", 64'(mem_len_o), 64'(exp_len));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("mem_rd_held", 64'(mem_rd_o), 64'd1);
    mem_accept_i = 1'b1;
    @(posedge clk_i); #1;
    mem_accept_i = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      mem_valid_i    = 1'b1;
      mem_data_i     = memWord(exp_addr + 32'(8 * i));
      mem_error_i    = (i == err_beat);
      mem_last_i     = (i == nbeats - 1);
      icache_flush_i = (i == flush_beat);
      @(posedge clk_i); #1;
    end
    mem_valid_i    = 1'b0;
    mem_error_i    = 1'b0;
    mem_last_i     = 1'b0;
    icache_flush_i = 1'b0;
    @(negedge clk_i);
    checkOutput("resp_latency", 64'(icache_valid_o), 64'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic checkFlushWindow(input string tag);
    int hi = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (icache_accept_o) hi++;
    end
    checkOutput({tag, "_accept_low"}, 64'(hi), 64'd0);
    @(negedge clk_i);
    checkOutput({tag, "_accept_back"}, 64'(icache_accept_o), 64'd1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    int base_rd;
    int base_valid;
    icache_rd_i = 1'b0;
    icache_pc_i = 32'd0;
    icache_priv_i = PRIV_MACHINE;
    icache_flush_i = 1'b0;
    icache_invalidate_i = 1'b0;
    mem_accept_i = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i = 64'd0;
    mem_error_i = 1'b0;
    mem_last_i = 1'b0;
    rst_i = 1'b1;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_accept", 64'(icache_accept_o), 64'd0);
    checkOutput("rst_valid", 64'(icache_valid_o), 64'd0);
    checkOutput("rst_error", 64'(icache_error_o), 64'd0);
    checkOutput("rst_inst", icache_inst_o, 64'd0);
    checkOutput("rst_mem_rd", 64'(mem_rd_o), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("rst_mem_len", 64'(mem_len_o), 64'd0);
    checkOutput("page_fault", 64'(icache_page_fault_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    $display("[TB] reset flush window");
    checkFlushWindow("reset");
    checkOutput("idle_no_valid", 64'(valid_cycles.size()), 64'd0);

    $display("[TB] cold miss");
    applyStimulus(32'h8000_0010, memWord(32'h8000_0010), 1'b0, w);
    serveBurst(32'h8000_0000, 8'd3, 4, -1, -1);
    waitDrain();

    $display("[TB] hit stream");
    base_rd = mem_rd_cycles;
    base_valid = valid_cycles.size();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h8000_0000 + 32'(8 * i), memWord(32'h8000_0000 + 32'(8 * i)), 1'b0, w);
      checkOutput("hit_accept_held", 64'(w), 64'd0);
    end
    waitDrain();
    checkOutput("hit_count", 64'(valid_cycles.size() - base_valid), 64'd4);
    checkOutput("hit_consecutive", 64'(valid_cycles[$] - valid_cycles[base_valid]), 64'd3);
    checkOutput("hit_no_refill", 64'(mem_rd_cycles - base_rd), 64'd0);

    $display("[TB] refill error");
    applyStimulus(32'h8000_0100, memWord(32'h8000_0100), 1'b1, w);
    serveBurst(32'h8000_0100, 8'd3, 4, 1, -1);
    waitDrain();
    applyStimulus(32'h8000_0100, memWord(32'h8000_0100), 1'b0, w);
    serveBurst(32'h8000_0100, 8'd3, 4, -1, -1);
    waitDrain();

    $display("[TB] early last beat");
    applyStimulus(32'h8000_0300, memWord(32'h8000_0300), 1'b0, w);
    serveBurst(32'h8000_0300, 8'd3, 2, -1, -1);
    waitDrain();
    applyStimulus(32'h8000_0300, memWord(32'h8000_0300), 1'b0, w);
    serveBurst(32'h8000_0300, 8'd3, 4, -1, -1);
    waitDrain();
    base_rd = mem_rd_cycles;
    applyStimulus(32'h8000_0318, memWord(32'h8000_0318), 1'b0, w);
    waitDrain();
    checkOutput("refilled_hit_no_bus", 64'(mem_rd_cycles - base_rd), 64'd0);

    $display("[TB] flush during refill");
    applyStimulus(32'h8000_0208, memWord(32'h8000_0208), 1'b0, w);
    serveBurst(32'h8000_0200, 8'd3, 4, -1, 1);
    checkFlushWindow("flush_wait");
    checkOutput("flush_sb_empty", 64'(sb.size()), 64'd0);
    applyStimulus(32'h8000_0000, memWord(32'h8000_0000), 1'b0, w);
    serveBurst(32'h8000_0000, 8'd3, 4, -1, -1);
    waitDrain();

    $display("[TB] invalidate collides with request");
    icache_rd_i = 1'b1;
    icache_pc_i = 32'h8000_0000;
    icache_invalidate_i = 1'b1;
    @(negedge clk_i);
    checkOutput("flush_wins_accept", 64'(icache_accept_o), 64'd0);
    @(posedge clk_i); #1;
    icache_rd_i = 1'b0;
    icache_invalidate_i = 1'b0;
    checkFlushWindow("invalidate");
    applyStimulus(32'h8000_0318, memWord(32'h8000_0318), 1'b0, w);
    serveBurst(32'h8000_0300, 8'd3, 4, -1, -1);
    waitDrain();

`ifdef BIRISCV_ICACHE_UNCACHED_EN
    $display("[TB] uncached region");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(32'hF000_0008, memWord(32'hF000_0008), 1'b0, w);
      serveBurst(32'hF000_0008, 8'd0, 1, -1, -1);
      waitDrain();
    end
`endif

    checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biriscv_icache_resp.md
Name: biriscv_icache_resp

Overview:
- Instruction-side responder for the fetch unit's icache_* request/response interface.
- Small direct-mapped, read-only instruction cache.
- Returns one 64-bit fetch word per accepted request.
- Refills lines over a burst read port toward the memory/bus bridge; services flush requests.

Parameters:
NUM_LINES, 64, number of cache lines (power of 2, >=2)
LINE_WORDS, 4, 64-bit words per line (power of 2, 2..16)
UNCACHED_TOP, 4'hF, value of pc[31:28] treated as uncached (only used with optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
icache_rd_i  in  1  fetch request
icache_pc_i  in  32  fetch address, 8-byte aligned; bits [2:0] ignored
icache_priv_i  in  2  privilege; carried, unused for lookup
icache_flush_i  in  1  invalidate whole cache (pulse)
icache_invalidate_i  in  1  treated identically to icache_flush_i
icache_accept_o  out  1  request accepted this cycle when icache_rd_i=1
icache_valid_o  out  1  response valid (single-cycle pulse)
icache_inst_o  out  64  fetch word
icache_error_o  out  1  bus error on refill
icache_page_fault_o  out  1  tied 0
mem_rd_o  out  1  burst read request
mem_addr_o  out  32  line-aligned (or word-aligned when uncached) address
mem_len_o  out  8  beats-1
mem_accept_i  in  1  burst request accepted
mem_valid_i  in  1  read beat valid
mem_data_i  in  64  read beat data
mem_error_i  in  1  beat error
mem_last_i  in  1  final beat

Behaviour:
- Address split: word = pc[3 +: log2(LINE_WORDS)], index = next log2(NUM_LINES) bits, tag = remaining upper bits. Defaults: word pc[4:3], index pc[10:5], tag pc[31:11].
- States: FLUSH, LOOKUP, REFILL, WAIT, RESP.
- Reset: state=FLUSH, flush counter=0.
- Reset values of outputs: accept=0, valid=0, error=0, inst=0, mem_rd=0, mem_addr=0, mem_len=0.
- Reset mid-refill: abandons the burst. Remaining mem beats arriving after reset are ignored (WAIT is not active).
- FLUSH:
  - Clears one valid bit per cycle, index 0..NUM_LINES-1; accept=0.
  - After the last index, goes to LOOKUP. Duration is exactly NUM_LINES cycles.
- LOOKUP:
  - accept=1 unless a flush is pending.
  - Request accepted in cycle N; tag/data RAM read is synchronous.
  - Cycle N+1 compares tag and valid bit.
  - Hit: valid=1 in N+1 with the word; accept=1 again in N+1, so back-to-back hits sustain 1 word/cycle.
  - Miss: accept=0 in N+1, go REFILL.
- REFILL:
  - mem_rd=1, mem_addr={tag,index,0}, mem_len=LINE_WORDS-1.
  - Held until mem_accept_i, then go WAIT.
- WAIT:
  - Each mem_valid_i beat writes data RAM at {index,beat_cnt}; beat_cnt increments.
  - The beat whose cnt equals the requested word is captured.
  - Any mem_error_i sets a sticky error flag.
  - On mem_last_i, go RESP. The valid bit is set only if the error flag is clear; the tag is written on the last beat.
- RESP:
  - valid=1 for one cycle with the captured word and error=error flag.
  - Error flag then clears; state returns to LOOKUP.
  - Response latency on a miss = 1 cycle after the last beat.
- Exactly one icache_valid_o pulse per accepted request. A fetch-side drop of the response is the requester's concern.
- Flush handling:
  - Flush in LOOKUP with no outstanding request: next state FLUSH.
  - Flush with a request in flight (compare cycle, REFILL, WAIT, RESP): latched as pending. The current response completes normally, then FLUSH. The line being refilled is not marked valid.
  - Flush during FLUSH: counter restarts at 0.
  - Flush and icache_rd_i in the same LOOKUP cycle: flush wins, accept=0.
- A beat arriving with mem_last_i early (before LINE_WORDS beats) still ends the refill; the line is not validated.

Optional Feature:
- BIRISCV_ICACHE_UNCACHED_EN defined:
  - Requests with pc[31:28]==UNCACHED_TOP skip tag compare.
  - They issue a single-beat read: mem_addr={pc[31:3],3'b0}, mem_len=0.
  - Data is returned in RESP; nothing is allocated.
  - Response latency = 1 cycle after the beat.
- Not defined: all addresses are cached; UNCACHED_TOP is ignored.

Decomposition:
- Shared package holds:
  - State encoding localparams (FLUSH/LOOKUP/REFILL/WAIT/RESP).
  - Address-split width functions.
  - PRIV_MACHINE, reused from the existing defines.
- One sub-module: biriscv_icache_resp_ram, a simple dual-port synchronous RAM (1 write, 1 read), instantiated for data and for tag+valid.

Test Plan:
- Reset then idle: accept=0 for 64 cycles, accept=1 in cycle 65; valid never asserted.
- Cold miss at pc=0x8000_0010: mem_addr=0x8000_0000, len=3; beats D0..D3 with last on D3 -> valid one cycle later with inst=D2, error=0.
- Hit stream after the fill, pcs 0x8000_0000/08/10/18 issued back-to-back -> valid on 4 consecutive cycles with D0..D3, accept held 1.
- Error on beat 1 of a refill at 0x8000_0100 -> RESP with error=1; a re-request at the same pc misses again and issues a new burst.
- Flush pulsed during WAIT -> the current response completes; then accept=0 for 64 cycles; a re-request of 0x8000_0000 misses.
- With BIRISCV_ICACHE_UNCACHED_EN: pc=0xF000_0008 -> mem_addr=0xF000_0008, len=0, inst=beat data; a second request to the same pc again issues a bus read.
